// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, word-aligned imem request issue and an in-order
// {inst, pc} queue toward decode, with redirect-driven discard of stale fetches.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [OW-1:0] CAP = OW'(DEPTH);
  logic [31:0]   pc;
  logic [CW-1:0] inflight, drop, count, inflight_next;
  logic [OW-1:0] occupancy;
  logic [31:0]   pf_mem [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] pf_rd, pf_wr, q_rd, q_wr;
  logic          req_hs, rsp_keep, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign occupancy        = {1'b0, inflight} + {1'b0, count};
  assign o_imem_req_valid = !i_rst && (occupancy < CAP);
  assign o_imem_req_addr  = pc;
  assign req_hs           = o_imem_req_valid && i_imem_req_ready;
  assign o_inst_valid     = count != '0;
  assign o_inst           = o_inst_valid ? q_inst[q_rd] : '0;
  assign o_inst_pc        = o_inst_valid ? q_pc[q_rd] : '0;
  assign pop              = o_inst_valid && i_inst_ready;
  assign inflight_next    = inflight + CW'(req_hs) - CW'(i_imem_rsp_valid);
  // a response arriving alongside a redirect is stale by definition
  assign rsp_keep         = i_imem_rsp_valid && drop == '0 && !i_redirect_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      pf_rd    <= '0;
      pf_wr    <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
    end else begin
      inflight <= inflight_next;
      if (req_hs) pf_wr <= nxt(pf_wr);
      if (i_imem_rsp_valid) pf_rd <= nxt(pf_rd);
      if (i_redirect_valid) begin
        pc    <= {i_redirect_pc[31:2], 2'b00};
        drop  <= inflight_next;
        count <= '0;
        q_rd  <= '0;
        q_wr  <= '0;
      end else begin
        if (req_hs) pc <= pc + 32'd4;
        if (i_imem_rsp_valid && drop != '0) drop <= drop - 1'b1;
        if (rsp_keep) q_wr <= nxt(q_wr);
        if (pop) q_rd <= nxt(q_rd);
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (req_hs) pf_mem[pf_wr] <= pc;
    if (rsp_keep) begin
      q_inst[q_wr] <= i_imem_rsp_data;
      q_pc[q_wr]   <= pf_mem[pf_rd];
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst) !(i_imem_rsp_valid && inflight == '0));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plus randomized fetch traffic against a sequential-stream
// reference model and an in-order latency memory model.
module tb_instruction_fetch;
  // three entries let the registered-only issue rule sustain one instruction per cycle
  localparam int DEPTH = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        o_imem_req_valid, i_imem_req_ready = 1'b0;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_inst_valid, i_inst_ready = 1'b0;
  logic [31:0] o_inst, o_inst_pc;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
    .i_imem_req_ready(i_imem_req_ready),
    .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready)
  );

  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0, nout = 0, lat = 1;
  logic [31:0] exp_req, exp_out, p_tgt = '0, prev_tgt, prev_addr, head_pc;
  bit          p_ready, p_dec, p_redir = 1'b0, prev_redir, prev_stall;
  logic        obs_req_v, obs_inst_v;
  logic [31:0] obs_addr, obs_pc, obs_inst;

  task automatic cycle();
    obs_req_v  = o_imem_req_valid;
    obs_addr   = o_imem_req_addr;
    obs_inst_v = o_inst_valid;
    obs_pc     = o_inst_pc;
    obs_inst   = o_inst;
    if (prev_redir) begin
      check("redir_flush", 32'(obs_inst_v), 32'd0);
      check("redir_addr", obs_addr, prev_tgt);
    end else if (prev_stall) begin
      check("req_hold_valid", 32'(obs_req_v), 32'd1);
      check("req_hold_addr", obs_addr, prev_addr);
    end
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = $urandom;
    end
    i_imem_req_ready = p_ready;
    i_inst_ready     = p_dec;
    i_redirect_valid = p_redir;
    i_redirect_pc    = p_tgt;
    if (obs_req_v && p_ready) begin
      check("req_addr", obs_addr, exp_req);
      pend_addr.push_back(obs_addr);
      pend_due.push_back(cyc + lat);
      exp_req += 32'd4;
      check("capacity", 32'(pend_addr.size() <= DEPTH), 32'd1);
    end
    if (obs_inst_v && p_dec) begin
      check("out_pc", obs_pc, exp_out);
      check("out_inst", obs_inst, mem_word(exp_out));
      exp_out += 32'd4;
      nout++;
    end
    if (p_redir) begin
      exp_req = {p_tgt[31:2], 2'b00};
      exp_out = {p_tgt[31:2], 2'b00};
    end
    prev_redir = p_redir;
    prev_tgt   = {p_tgt[31:2], 2'b00};
    prev_stall = obs_req_v && !p_ready;
    prev_addr  = obs_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_redirect_valid = 1'b0;
    i_imem_req_ready = 1'b0;
    i_inst_ready = 1'b0;
    #1;
    check("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
    check("rst_req_addr", o_imem_req_addr, RESET_PC);
    check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_inst_pc", o_inst_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_req = RESET_PC;
    exp_out = RESET_PC;
    prev_redir = 1'b0;
    prev_stall = 1'b0;
    p_redir = 1'b0;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    p_redir = 1'b1;
    p_tgt = tgt;
    cycle();
    p_redir = 1'b0;
  endtask

  initial begin
    do_reset();
    p_ready = 1'b1;
    p_dec = 1'b1;
    lat = 1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("throughput", 32'(obs_inst_v), 32'(k >= 2));
    end
    redirect(32'h0000_0103);
    run(8);
    lat = 3;
    run(4);
    redirect(32'h0000_0203);
    lat = 1;
    run(10);
    redirect(32'hFFFF_FFF8);
    run(8);
    p_dec = 1'b0;
    run(3);
    head_pc = o_inst_pc;
    run(7);
    check("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
    check("stall_head_valid", 32'(o_inst_valid), 32'd1);
    check("stall_head_pc", o_inst_pc, head_pc);
    p_dec = 1'b1;
    run(10);
    p_dec = 1'b0;
    lat = 3;
    run(4);
    do_reset();
    p_dec = 1'b1;
    lat = 1;
    run(6);
    for (int i = 0; i < 3000; i++) begin
      p_ready = $urandom_range(0, 3) != 0;
      p_dec   = $urandom_range(0, 3) != 0;
      lat     = $urandom_range(1, 4);
      p_redir = $urandom_range(0, 24) == 0;
      p_tgt   = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      cycle();
    end
    p_redir = 1'b0;
    check("progress", 32'(nout > 500), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
